seg_scan_driver: RTL



---
 rtl/calc_pkg.sv | 32 +++
 rtl/seg_frame_builder.sv | 51 +++++
 rtl/seg_scan_driver.sv | 131 +++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared types and helpers for the seven-segment scan driver.
// Segment patterns are active-high in the order {dp,g,f,e,d,c,b,a}.
package calc_pkg;

  typedef logic [7:0] SegPattern;

  localparam SegPattern MinusPattern = 8'h40;
  localparam SegPattern BlankPattern = 8'h00;

  // Standard hex glyphs 0-9, A, b, C, d, E, F with the decimal point off.
  function automatic SegPattern hex_decode(input logic [3:0] nibble);
    case (nibble)
      4'h0:    hex_decode = 8'h3F;
      4'h1:    hex_decode = 8'h06;
      4'h2:    hex_decode = 8'h5B;
      4'h3:    hex_decode = 8'h4F;
      4'h4:    hex_decode = 8'h66;
      4'h5:    hex_decode = 8'h6D;
      4'h6:    hex_decode = 8'h7D;
      4'h7:    hex_decode = 8'h07;
      4'h8:    hex_decode = 8'h7F;
      4'h9:    hex_decode = 8'h6F;
      4'hA:    hex_decode = 8'h77;
      4'hB:    hex_decode = 8'h7C;
      4'hC:    hex_decode = 8'h39;
      4'hD:    hex_decode = 8'h5E;
      4'hE:    hex_decode = 8'h79;
      default: hex_decode = 8'h71;
    endcase
  endfunction

endpackage

// File: rtl/seg_frame_builder.sv
// Combinational frame builder: places the hex digits after a left shift,
// blanks leading zeros on request and puts the minus sign just above the
// most significant shown digit when there is room for it.
module seg_frame_builder
  import calc_pkg::*;
#(
  parameter  int NumDigits = 8,
  localparam int SW        = $clog2(NumDigits)
) (
  input  logic [NumDigits*4-1:0] digits,
  input  logic [NumDigits-1:0]   dp,
  input  logic                   negative,
  input  logic                   blank_leading,
  input  logic [SW-1:0]          shift,
  output logic [NumDigits*8-1:0] frame
);

  // Index of the most significant source digit that is shown.
  int top;

  // Find the highest shown source digit; digit 0 is always shown.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    top = NumDigits - 1;
    if (blank_leading) begin
      top = 0;
      for (int j = 1; j < NumDigits; j++) begin
        if (digits[j*4 +: 4] != 4'h0) top = j;
      end
    end
  end

  // Position p shows source digit p - shift; a shift that pushes every
  // digit off the top naturally yields an all-blank frame.
  always_comb begin
    frame = '0;
    for (int p = 0; p < NumDigits; p++) begin
      frame[p*8 +: 8] = BlankPattern;
      for (int j = 0; j < NumDigits; j++) begin
        if (p == j + int'(shift) && j <= top) begin
          frame[p*8 +: 8] = hex_decode(digits[j*4 +: 4]) | {dp[j], 7'b0};
        end
      end
      if (negative && p == top + 1 + int'(shift)) begin
        frame[p*8 +: 8] = MinusPattern;
      end
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Seven-segment scan driver: snapshots a tear-free frame once per scan and
// time-multiplexes it onto shared cathodes and one-hot anodes, with a
// phase-compare PWM for brightness.
module seg_scan_driver
  import calc_pkg::*;
#(
  parameter  int NumDigits        = 8,
  parameter  int ScanDiv          = 1000,
  parameter  int BrightBits       = 3,
  parameter  bit ActiveLowCathode = 1'b1,
  parameter  bit ActiveLowAnode   = 1'b1,
  localparam int SW               = $clog2(NumDigits)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumDigits*4-1:0] digits_i,
  input  logic [NumDigits-1:0]   dp_i,
  input  logic                   negative_i,
  input  logic                   blank_leading_i,
  input  logic [BrightBits-1:0]  brightness_i,
  input  logic                   override_shift_amount_i,
  input  logic [SW-1:0]          new_shift_amount_i,
  output logic [NumDigits*8-1:0] display_segments_o,
  output logic [7:0]             segments_cathode_o,
  output logic [NumDigits-1:0]   segments_anode_o,
  output logic                   frame_start_o
);

  localparam int PW = $clog2(ScanDiv);
  localparam SegPattern CathodeOff = {8{ActiveLowCathode}};
  localparam logic [NumDigits-1:0] AnodeOff = {NumDigits{ActiveLowAnode}};

  logic [PW-1:0]          prescaler;
  logic [SW-1:0]          index;
  logic [SW-1:0]          shift;
  logic [BrightBits-1:0]  phase;
  logic [BrightBits-1:0]  bright;
  logic                   slot_end;
  logic                   wrap;
  logic                   enable;
  logic [NumDigits*8-1:0] built;
  SegPattern              current;
  logic [NumDigits-1:0]   select;

  assign slot_end = (prescaler == PW'(ScanDiv - 1));
  assign wrap     = slot_end && (index == SW'(NumDigits - 1));
  assign enable   = (phase <= bright);

  seg_frame_builder #(
    .NumDigits(NumDigits)
  ) u_builder (
    .digits       (digits_i),
    .dp           (dp_i),
    .negative     (negative_i),
    .blank_leading(blank_leading_i),
    .shift        (shift),
    .frame        (built)
  );

  // Shift amount register; while override is held the last value wins.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift <= '0;
    end else if (override_shift_amount_i) begin
      shift <= new_shift_amount_i;
    end
  end

  // Slot prescaler and digit index; the index wraps back to 0 after the last digit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prescaler <= '0;
      index     <= '0;
    end else if (slot_end) begin
      prescaler <= '0;
      index     <= wrap ? '0 : index + SW'(1);
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  // Free-running PWM phase counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase <= '0;
    end else begin
      phase <= phase + BrightBits'(1);
    end
  end

  // Frame snapshot on the wrap edge, using the shift registered before it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      display_segments_o <= '0;
      bright             <= '0;
      frame_start_o      <= 1'b0;
    end else begin
      frame_start_o <= wrap;
      if (wrap) begin
        display_segments_o <= built;
        bright             <= brightness_i;
      end
    end
  end

  // Pick the current digit's pattern and its one-hot anode select.
  always_comb begin
    current = BlankPattern;
    select  = '0;
    for (int d = 0; d < NumDigits; d++) begin
      if (index == SW'(d)) begin
        current   = display_segments_o[d*8 +: 8];
        select[d] = enable;
      end
    end
  end

  // Registered pin drivers at pin polarity; segments are off whenever the anode is off.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      segments_cathode_o <= CathodeOff;
      segments_anode_o   <= AnodeOff;
    end else begin
      segments_cathode_o <= (enable ? current : BlankPattern) ^ CathodeOff;
      segments_anode_o   <= select ^ AnodeOff;
    end
  end

endmodule
